resend_q: RTL and testbench



---
 rtl/ring_pkg.sv | 25 ++
 rtl/resend_q_if.sv | 21 ++
 rtl/resend_q_ram.sv | 22 ++
 rtl/resend_q.sv | 62 ++++++
 tb/tb_resend_q.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/ring_pkg.sv
// Ring-wide slot definitions shared by the memory controller blocks.
package ring_pkg;

    localparam int unsigned DEST_W  = 4;
    localparam int unsigned TYPE_W  = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ENTRY_W = DEST_W + TYPE_W + DATA_W;

    typedef enum logic [TYPE_W-1:0] {
        SLOT_TOKEN     = 4'd1,
        SLOT_ADDRESS   = 4'd2,
        SLOT_WRITEDATA = 4'd3,
        SLOT_NULL      = 4'd7
    } slot_type_e;

    localparam logic [TYPE_W-1:0] RESEND_READ_ACK = 4'b0110;
    localparam logic [TYPE_W-1:0] RESEND_ADDRESS  = 4'b0010;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [TYPE_W-1:0] slot_type;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/resend_q_if.sv
// Producer/consumer handshake bundle for the resend queue.
interface resend_q_if #(
    parameter int unsigned WIDTH = 40
);
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;

    modport master (
        output din, wr_en, rd_en,
        input  dout, full, empty
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, full, empty
    );
endinterface

// File: rtl/resend_q_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read, no reset.
module resend_q_ram #(
    parameter int unsigned WIDTH   = 40,
    parameter int unsigned LOGSIZE = 9
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [LOGSIZE-1:0] i_waddr,
    input  logic [WIDTH-1:0]   i_wdata,
    input  logic [LOGSIZE-1:0] i_raddr,
    output logic [WIDTH-1:0]   o_rdata
);
    logic [WIDTH-1:0] r_mem [1 << LOGSIZE];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/resend_q.sv
// First-word-fall-through queue of ring slots awaiting re-injection.
module resend_q
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH   = ENTRY_W,
    parameter int unsigned LOGSIZE = 9
) (
    input  logic         clk,
    input  logic         rst,
    resend_q_if.slave    q
);
    localparam logic [LOGSIZE:0] DEPTH_CNT = {1'b1, {LOGSIZE{1'b0}}};

    logic [LOGSIZE-1:0] r_wr_ptr;
    logic [LOGSIZE-1:0] r_rd_ptr;
    logic [LOGSIZE:0]   r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_rdata;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == DEPTH_CNT);
    assign w_wr_acc = q.wr_en & ~w_full;
    assign w_rd_acc = q.rd_en & ~w_empty;

    resend_q_ram #(
        .WIDTH   (WIDTH),
        .LOGSIZE (LOGSIZE)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (q.din),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{LOGSIZE{1'b0}}, w_wr_acc}
                               - {{LOGSIZE{1'b0}}, w_rd_acc};
        end
    end

    // Stale RAM contents are masked so an empty queue always presents zero.
    assign q.dout  = w_empty ? '0 : w_rdata;
    assign q.empty = w_empty;
    assign q.full  = w_full;
endmodule

// File: tb/tb_resend_q.sv
// Scoreboard bench for resend_q against a queue-based reference model.
module tb_resend_q;
    localparam int unsigned WIDTH   = 40;
    localparam int unsigned LOGSIZE = 9;
    localparam int unsigned DEPTH   = 1 << LOGSIZE;

    logic clk = 1'b0;
    logic rst = 1'b0;

    resend_q_if #(.WIDTH(WIDTH)) qif ();

    resend_q #(
        .WIDTH   (WIDTH),
        .LOGSIZE (LOGSIZE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (qif.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] model_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue with the accept rules applied to its size.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_q.delete();
        end else begin
            automatic bit wa = qif.wr_en && (model_q.size() < DEPTH);
            automatic bit ra = qif.rd_en && (model_q.size() > 0);
            if (ra) void'(model_q.pop_front());
            if (wa) model_q.push_back(qif.din);
        end
    end

    // Monitor: compares DUT outputs against the model head on every falling edge.
    always @(negedge clk) begin
        automatic logic [WIDTH-1:0] exp_dout = (model_q.size() > 0) ? model_q[0] : '0;
        chk("empty", 64'(qif.empty), 64'(model_q.size() == 0));
        chk("full",  64'(qif.full),  64'(model_q.size() == DEPTH));
        chk("dout",  64'(qif.dout),  64'(exp_dout));
    end

    task automatic cyc(input logic w, input logic r, input logic [WIDTH-1:0] d);
        @(negedge clk);
        qif.wr_en = w;
        qif.rd_en = r;
        qif.din   = d;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0);
    endtask

    task automatic drain(output int n);
        n = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            @(negedge clk);
            qif.wr_en = 1'b0;
            qif.din   = '0;
            qif.rd_en = ~qif.empty;
            if (!qif.empty) n++;
        end
        idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int n;
        qif.wr_en = 1'b0;
        qif.rd_en = 1'b0;
        qif.din   = '0;

        // Reset hold for three cycles
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_empty", 64'(qif.empty), 64'd1);
        chk("reset_full",  64'(qif.full),  64'd0);
        chk("reset_dout",  64'(qif.dout),  64'd0);

        // Single push/pop
        cyc(1'b1, 1'b0, 40'h26_0000_0123);
        idle();
        #1 chk("single_push_dout", 64'(qif.dout), 64'h26_0000_0123);
        chk("single_push_empty", 64'(qif.empty), 64'd0);
        cyc(1'b0, 1'b1, '0);
        idle();
        #1 chk("single_pop_empty", 64'(qif.empty), 64'd1);
        chk("single_pop_dout", 64'(qif.dout), 64'd0);

        // Ordering 1..5
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, WIDTH'(i));
        drain(n);
        chk("order_count", 64'(n), 64'd5);

        // Full boundary, dropped 513th push with and without a read
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, WIDTH'(i));
        idle();
        #1 chk("full_after_512", 64'(qif.full), 64'd1);
        cyc(1'b1, 1'b0, 40'hFF_DEAD_BEEF);
        cyc(1'b1, 1'b1, 40'hFF_BAD0_BAD0);
        idle();
        #1 chk("drop_with_read_full", 64'(qif.full), 64'd0);
        chk("drop_with_read_head", 64'(qif.dout), 64'd1);
        drain(n);
        chk("full_drain_count", 64'(n), 64'(DEPTH - 1));

        // Simultaneous read/write across pointer wrap (pointers pre-advanced to 510)
        do_reset();
        for (int i = 0; i < 510; i++) begin
            cyc(1'b1, 1'b0, WIDTH'(i));
            cyc(1'b0, 1'b1, '0);
        end
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, WIDTH'(32'hA000 + i));
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, {$urandom(), $urandom()});
        idle();
        #1 chk("simul_not_empty", 64'(qif.empty), 64'd0);
        drain(n);
        chk("simul_count_kept", 64'(n), 64'd3);

        // Empty boundary: write kept, read ignored
        cyc(1'b1, 1'b1, 40'hA);
        idle();
        #1 chk("empty_rw_dout", 64'(qif.dout), 64'hA);
        chk("empty_rw_empty", 64'(qif.empty), 64'd0);
        drain(n);
        chk("empty_rw_count", 64'(n), 64'd1);

        // Random traffic with a mid-burst asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 45),
                {$urandom(), $urandom()});
            if (i == 1500) begin
                @(posedge clk);
                #2 rst = 1'b0;
                #1;
                chk("async_rst_empty", 64'(qif.empty), 64'd1);
                chk("async_rst_full",  64'(qif.full),  64'd0);
                chk("async_rst_dout",  64'(qif.dout),  64'd0);
                @(negedge clk);
                rst = 1'b1;
            end
        end
        drain(n);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
